// File: rtl/regfile_param_2r2w.sv
// Two-read / two-write register file with per-entry valid bits and a sequential clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to reads of the same address.
module regfile_param_2r2w #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 40,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd0_valid,
  output logic              rd1_valid,
  input  logic              wr0_en,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [WIDTH-1:0]  wr0_data,
  input  logic [WIDTH-1:0]  wr1_data,
  output logic              wr_ready,
  output logic              wr_collision,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [0:0]        IDLE    = 1'b0;
  localparam logic [0:0]        CLEAR   = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic             wr0_ok, wr1_ok;
  logic [WIDTH-1:0] rd0_next, rd1_next;
  logic             rd0_vnext, rd1_vnext;

  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == CLEAR) && (ptr == LAST);
  assign wr0_ok   = wr0_en && wr_ready && ({1'b0, wr0_addr} < DEPTH_W);
  assign wr1_ok   = wr1_en && wr_ready && ({1'b0, wr1_addr} < DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (clr_start) begin
        state <= CLEAR;
        ptr   <= '0;
      end
    end else if (ptr == LAST) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

  // Writes only happen in IDLE, so they never race the sweep; wr1 is last and wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (state == CLEAR) begin
      mem[ptr]   <= '0;
      valid[ptr] <= 1'b0;
    end else begin
      if (wr0_ok) begin
        mem[wr0_addr]   <= wr0_data;
        valid[wr0_addr] <= 1'b1;
      end
      if (wr1_ok) begin
        mem[wr1_addr]   <= wr1_data;
        valid[wr1_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_collision <= 1'b0;
    else     wr_collision <= wr0_ok && wr1_ok && (wr0_addr == wr1_addr);
  end

  always_comb begin
    rd0_next  = '0;
    rd0_vnext = 1'b0;
    if ({1'b0, rd0_addr} < DEPTH_W) begin
      rd0_next  = mem[rd0_addr];
      rd0_vnext = valid[rd0_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && (wr1_addr == rd0_addr)) begin
        rd0_next  = wr1_data;
        rd0_vnext = 1'b1;
      end else if (wr0_ok && (wr0_addr == rd0_addr)) begin
        rd0_next  = wr0_data;
        rd0_vnext = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    rd1_next  = '0;
    rd1_vnext = 1'b0;
    if ({1'b0, rd1_addr} < DEPTH_W) begin
      rd1_next  = mem[rd1_addr];
      rd1_vnext = valid[rd1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && (wr1_addr == rd1_addr)) begin
        rd1_next  = wr1_data;
        rd1_vnext = 1'b1;
      end else if (wr0_ok && (wr0_addr == rd1_addr)) begin
        rd1_next  = wr0_data;
        rd1_vnext = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data  <= '0;
      rd1_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
    end else begin
      rd0_data  <= rd0_next;
      rd1_data  <= rd1_next;
      rd0_valid <= rd0_vnext;
      rd1_valid <= rd1_vnext;
    end
  end

endmodule

// File: tb/tb_regfile_param_2r2w.sv
// Directed self-checking bench for regfile_param_2r2w: writes, collisions, bypass, clear sweep, reset abort.
module tb_regfile_param_2r2w;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 40;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] rd0_addr = '0, rd1_addr = '0;
  logic [WIDTH-1:0]  rd0_data, rd1_data;
  logic              rd0_valid, rd1_valid;
  logic              wr0_en = 1'b0, wr1_en = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [WIDTH-1:0]  wr0_data = '0, wr1_data = '0;
  logic              wr_ready, wr_collision;
  logic              clr_start = 1'b0;
  logic              clr_busy, clr_done;

  int vec_count   = 0;
  int miscompares = 0;

  regfile_param_2r2w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
    .wr0_en(wr0_en), .wr1_en(wr1_en),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr_ready(wr_ready), .wr_collision(wr_collision),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it, so inputs change and outputs are sampled off-edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vec_count++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    int ready_bad;
    int nonzero;
    logic [WIDTH-1:0] exp_byp_data;
    logic             exp_byp_valid;

    // Reset takes effect immediately, without a clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_wr_ready", 64'(wr_ready), 64'd1);
    checkOutput("rst_clr_busy", 64'(clr_busy), 64'd0);
    checkOutput("rst_rd0_data", rd0_data, 64'd0);
    checkOutput("rst_rd0_valid", 64'(rd0_valid), 64'd0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Basic write then read; unwritten neighbour reads as empty.
    wr0_en = 1'b1; wr0_addr = 6'd5; wr0_data = 64'hA5A5;
    applyStimulus();
    wr0_en = 1'b0;
    rd0_addr = 6'd5; rd1_addr = 6'd6;
    applyStimulus();
    checkOutput("rd5_data", rd0_data, 64'hA5A5);
    checkOutput("rd5_valid", 64'(rd0_valid), 64'd1);
    checkOutput("rd6_data", rd1_data, 64'd0);
    checkOutput("rd6_valid", 64'(rd1_valid), 64'd0);

    // Same-address dual write: wr1 wins, collision pulses for one cycle.
    wr0_en = 1'b1; wr0_addr = 6'd3; wr0_data = 64'd1;
    wr1_en = 1'b1; wr1_addr = 6'd3; wr1_data = 64'd2;
    applyStimulus();
    checkOutput("collision_hi", 64'(wr_collision), 64'd1);
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd0_addr = 6'd3;
    applyStimulus();
    checkOutput("collision_lo", 64'(wr_collision), 64'd0);
    checkOutput("rd3_data", rd0_data, 64'd2);

    // Read and write of address 7 sampled at the same edge.
`ifdef REGFILE_BYPASS_EN
    exp_byp_data = 64'd9; exp_byp_valid = 1'b1;
`else
    exp_byp_data = 64'd0; exp_byp_valid = 1'b0;
`endif
    wr0_en = 1'b1; wr0_addr = 6'd7; wr0_data = 64'd9;
    rd0_addr = 6'd7;
    applyStimulus();
    wr0_en = 1'b0;
    checkOutput("byp_data", rd0_data, exp_byp_data);
    checkOutput("byp_valid", 64'(rd0_valid), 64'(exp_byp_valid));
    applyStimulus();
    checkOutput("rd7_after", rd0_data, 64'd9);

    // Fill every entry two at a time with 100+addr.
    for (int i = 0; i < DEPTH; i += 2) begin
      wr0_en = 1'b1; wr0_addr = ADDR_W'(i);     wr0_data = 64'(100 + i);
      wr1_en = 1'b1; wr1_addr = ADDR_W'(i + 1); wr1_data = 64'(101 + i);
      applyStimulus();
    end
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd0_addr = 6'd39; rd1_addr = 6'd0;
    applyStimulus();
    checkOutput("fill_rd39", rd0_data, 64'd139);
    checkOutput("fill_rd0", rd1_data, 64'd100);

    // Start the sweep; the write in the same IDLE cycle lands and is later cleared.
    clr_start = 1'b1;
    wr0_en = 1'b1; wr0_addr = 6'd10; wr0_data = 64'hDEAD;
    applyStimulus();
    clr_start = 1'b0;
    checkOutput("clr_busy_hi", 64'(clr_busy), 64'd1);
    checkOutput("clr_ready_lo", 64'(wr_ready), 64'd0);
    // Reads during the sweep see pre-clear contents of the entry being cleared.
    wr0_addr = 6'd2; wr0_data = 64'hFFFF;
    rd0_addr = 6'd0;
    busy_cycles = 1; done_pulses = 0; ready_bad = 0;
    if (clr_done) done_pulses++;
    applyStimulus();
    checkOutput("clr_read_pre", rd0_data, 64'd100);
    for (int c = 0; c < 60; c++) begin
      if (!clr_busy) break;
      busy_cycles++;
      if (clr_done) done_pulses++;
      if (wr_ready) ready_bad++;
      applyStimulus();
    end
    wr0_en = 1'b0;
    checkOutput("clr_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
    checkOutput("clr_done_pulses", 64'(done_pulses), 64'd1);
    checkOutput("clr_ready_during", 64'(ready_bad), 64'd0);
    checkOutput("clr_ready_after", 64'(wr_ready), 64'd1);

    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd0_addr = ADDR_W'(i);
      applyStimulus();
      if (rd0_data != '0 || rd0_valid) nonzero++;
    end
    checkOutput("clr_all_zero", 64'(nonzero), 64'd0);

    // Reset mid-sweep at pointer 20.
    wr0_en = 1'b1; wr0_addr = 6'd39; wr0_data = 64'd77;
    applyStimulus();
    wr0_en = 1'b0;
    clr_start = 1'b1;
    rd0_addr = 6'd39;
    applyStimulus();
    clr_start = 1'b0;
    for (int c = 0; c < 20; c++) applyStimulus();
    checkOutput("mid_busy", 64'(clr_busy), 64'd1);
    checkOutput("mid_rd39", rd0_data, 64'd77);
    rst = 1'b1;
    #2;
    checkOutput("abort_ready", 64'(wr_ready), 64'd1);
    checkOutput("abort_busy", 64'(clr_busy), 64'd0);
    checkOutput("abort_done", 64'(clr_done), 64'd0);
    checkOutput("abort_rd0_data", rd0_data, 64'd0);
    checkOutput("abort_rd0_valid", 64'(rd0_valid), 64'd0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Post-reset write to the last entry and an out-of-range write/read.
    wr1_en = 1'b1; wr1_addr = 6'd39; wr1_data = 64'h1234;
    wr0_en = 1'b1; wr0_addr = 6'd45; wr0_data = 64'h5555;
    applyStimulus();
    wr0_en = 1'b0; wr1_en = 1'b0;
    rd0_addr = 6'd39; rd1_addr = 6'd45;
    applyStimulus();
    checkOutput("post_rd39_data", rd0_data, 64'h1234);
    checkOutput("post_rd39_valid", 64'(rd0_valid), 64'd1);
    checkOutput("post_rd45_data", rd1_data, 64'd0);
    checkOutput("post_rd45_valid", 64'(rd1_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
